// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants, bus request record and grant rule for the IF/MEM memory bus arbiter.
package mem_bus_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;

    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_IBUSY = 2'd1;
    localparam logic [1:0] ARB_DBUSY = 2'd2;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    localparam logic [SEL_W-1:0] SEL_WORD = 4'hF;

    typedef struct packed {
        logic              we;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

    // Returns 1 when the data port should be granted; only meaningful if at least one is eligible.
    function automatic logic pick_data(input logic data_prio, input logic if_elig,
                                       input logic d_elig, input logic last_grant);
        if (d_elig && !if_elig) return 1'b1;
        if (if_elig && !d_elig) return 1'b0;
        if (data_prio) return 1'b1;
        return (last_grant == PORT_IF);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_port_hold.sv
// Per-port completion holder: done flag, captured read data and stall request for one stage.
module mem_bus_arbiter_port_hold
    import mem_bus_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              ack_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic              done_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              stallreq_o
);

    logic              done_q, done_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // Flush beats a same-cycle ack; done otherwise holds until the stage is allowed to advance.
    always_comb begin
        done_d  = done_q;
        rdata_d = rdata_q;
        if (flush_i) begin
            done_d = 1'b0;
        end else if (ack_i) begin
            done_d  = 1'b1;
            rdata_d = bus_rdata_i;
        end else if (done_q && !stall_i) begin
            done_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    assign done_o     = done_q;
    assign rdata_o    = rdata_q;
    assign stallreq_o = req_i && !done_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one Wishbone-classic port between instruction fetch and load/store, holding each
// completed result until its pipeline stage advances.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter bit DATA_PRIO = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [DATA_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_stallreq_o,
    input  logic              if_stall_i,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [SEL_W-1:0]  d_sel_i,
    input  logic [DATA_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_stallreq_o,
    input  logic              d_stall_i,
    input  logic              flush_i,
    output logic              bus_cyc_o,
    output logic              bus_stb_o,
    output logic              bus_we_o,
    output logic [SEL_W-1:0]  bus_sel_o,
    output logic [DATA_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_ack_i
);

    logic [1:0] state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic       cyc_q, cyc_d;
    logic       kill_q, kill_d;
    bus_req_t   bus_q, bus_d;

    logic if_done, d_done;
    logic if_elig, d_elig;
    logic grant_data;
    logic if_ack, d_ack;

    assign if_elig = if_req_i && !if_done;
    assign d_elig  = d_req_i && !d_done;

    // kill_q marks an in-flight cycle whose result was flushed; the bus still completes it.
    assign if_ack = bus_ack_i && (state_q == ARB_IBUSY) && !kill_q;
    assign d_ack  = bus_ack_i && (state_q == ARB_DBUSY) && !kill_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cyc_d        = cyc_q;
        kill_d       = kill_q;
        bus_d        = bus_q;
        grant_data   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (if_elig || d_elig) begin
                    grant_data   = pick_data(DATA_PRIO, if_elig, d_elig, last_grant_q);
                    cyc_d        = 1'b1;
                    kill_d       = flush_i;
                    last_grant_d = grant_data;
                    if (grant_data) begin
                        bus_d.we    = d_we_i;
                        bus_d.sel   = d_sel_i;
                        bus_d.addr  = d_addr_i;
                        bus_d.wdata = d_wdata_i;
                        state_d     = ARB_DBUSY;
                    end else begin
                        bus_d.we    = 1'b0;
                        bus_d.sel   = SEL_WORD;
                        bus_d.addr  = if_addr_i;
                        bus_d.wdata = '0;
                        state_d     = ARB_IBUSY;
                    end
                end
            end
            ARB_IBUSY, ARB_DBUSY: begin
                if (bus_ack_i) begin
                    cyc_d   = 1'b0;
                    kill_d  = 1'b0;
                    state_d = ARB_IDLE;
                end else begin
                    kill_d = kill_q || flush_i;
                end
            end
            default: begin
                cyc_d   = 1'b0;
                kill_d  = 1'b0;
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= PORT_IF;
            cyc_q        <= 1'b0;
            kill_q       <= 1'b0;
            bus_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cyc_q        <= cyc_d;
            kill_q       <= kill_d;
            bus_q        <= bus_d;
        end
    end

    mem_bus_arbiter_port_hold u_if_hold (
        .clk         (clk),
        .rst         (rst),
        .req_i       (if_req_i),
        .stall_i     (if_stall_i),
        .flush_i     (flush_i),
        .ack_i       (if_ack),
        .bus_rdata_i (bus_rdata_i),
        .done_o      (if_done),
        .rdata_o     (if_rdata_o),
        .stallreq_o  (if_stallreq_o)
    );

    mem_bus_arbiter_port_hold u_d_hold (
        .clk         (clk),
        .rst         (rst),
        .req_i       (d_req_i),
        .stall_i     (d_stall_i),
        .flush_i     (flush_i),
        .ack_i       (d_ack),
        .bus_rdata_i (bus_rdata_i),
        .done_o      (d_done),
        .rdata_o     (d_rdata_o),
        .stallreq_o  (d_stallreq_o)
    );

    assign bus_cyc_o   = cyc_q;
    assign bus_stb_o   = cyc_q;
    assign bus_we_o    = bus_q.we;
    assign bus_sel_o   = bus_q.sel;
    assign bus_addr_o  = bus_q.addr;
    assign bus_wdata_o = bus_q.wdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed corner cases plus a randomized scoreboard run.
module tb_mem_bus_arbiter;

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        if_req, if_stall, d_req, d_we, d_stall, flush, bus_ack;
    logic [31:0] if_addr, d_addr, d_wdata, bus_rdata;
    logic [3:0]  d_sel;
    logic [31:0] if_rdata, d_rdata, bus_addr, bus_wdata;
    logic        if_stallreq, d_stallreq, bus_cyc, bus_stb, bus_we;
    logic [3:0]  bus_sel;

    logic        rr_if_req, rr_if_stall, rr_d_req, rr_d_stall, rr_ack;
    logic [31:0] rr_if_addr, rr_d_addr, rr_rdata;
    logic [31:0] rr_if_rdata, rr_d_rdata, rr_bus_addr, rr_bus_wdata;
    logic        rr_if_stallreq, rr_d_stallreq, rr_bus_cyc, rr_bus_stb, rr_bus_we;
    logic [3:0]  rr_bus_sel;

    mem_bus_arbiter #(.DATA_PRIO(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata),
        .if_stallreq_o(if_stallreq), .if_stall_i(if_stall),
        .d_req_i(d_req), .d_we_i(d_we), .d_sel_i(d_sel), .d_addr_i(d_addr),
        .d_wdata_i(d_wdata), .d_rdata_o(d_rdata), .d_stallreq_o(d_stallreq),
        .d_stall_i(d_stall), .flush_i(flush),
        .bus_cyc_o(bus_cyc), .bus_stb_o(bus_stb), .bus_we_o(bus_we), .bus_sel_o(bus_sel),
        .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata), .bus_rdata_i(bus_rdata),
        .bus_ack_i(bus_ack)
    );

    mem_bus_arbiter #(.DATA_PRIO(1'b0)) u_rr (
        .clk(clk), .rst(rst),
        .if_req_i(rr_if_req), .if_addr_i(rr_if_addr), .if_rdata_o(rr_if_rdata),
        .if_stallreq_o(rr_if_stallreq), .if_stall_i(rr_if_stall),
        .d_req_i(rr_d_req), .d_we_i(1'b0), .d_sel_i(4'hF), .d_addr_i(rr_d_addr),
        .d_wdata_i(32'h0), .d_rdata_o(rr_d_rdata), .d_stallreq_o(rr_d_stallreq),
        .d_stall_i(rr_d_stall), .flush_i(1'b0),
        .bus_cyc_o(rr_bus_cyc), .bus_stb_o(rr_bus_stb), .bus_we_o(rr_bus_we),
        .bus_sel_o(rr_bus_sel), .bus_addr_o(rr_bus_addr), .bus_wdata_o(rr_bus_wdata),
        .bus_rdata_i(rr_rdata), .bus_ack_i(rr_ack)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tfail(input string name);
        total++;
        bad++;
        $display("FAIL %s: condition not met within bound", name);
    endtask

    // Slave memory contents: a fixed scramble of the address.
    function automatic logic [31:0] slave_data(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    // Slave behaviour and scoreboard state
    int          slave_waits = 0;   // -1: random 0..3 wait states
    bit          slave_force_ack = 1'b0;
    bit          use_fix = 1'b0;
    logic [31:0] fix_data = 32'h0;
    bit          sb_en = 1'b0;
    bit          pend_if = 1'b0, pend_d = 1'b0;
    txn_t        if_bus_q[$], d_bus_q[$];
    logic [31:0] if_rd_q[$], d_rd_q[$];

    bit   in_cyc = 1'b0, cyc_prev = 1'b0, cur_d = 1'b0, snap_if = 1'b0, snap_d = 1'b0;
    int   wcnt = 0;
    txn_t cur = '0;

    // Monitor + Wishbone slave, all evaluated on the falling edge
    initial begin
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (sb_en) begin
                if (bus_cyc && !cyc_prev) begin
                    if (!snap_if && !snap_d) begin
                        tfail("sb_unexpected_cycle");
                    end else begin
                        cur_d = snap_d;
                        if (cur_d && d_bus_q.size() > 0) cur = d_bus_q.pop_front();
                        else if (!cur_d && if_bus_q.size() > 0) cur = if_bus_q.pop_front();
                        else tfail("sb_queue_empty");
                        chk(cur_d ? "sb_d_issue" : "sb_if_issue",
                            96'({bus_stb, bus_we, bus_sel, bus_addr, bus_wdata}), 96'({1'b1, cur}));
                    end
                end else if (bus_cyc) begin
                    chk("sb_bus_stable", 96'({bus_stb, bus_we, bus_sel, bus_addr, bus_wdata}),
                        96'({1'b1, cur}));
                end
                if (if_req && !if_stallreq) begin
                    if (if_rd_q.size() == 0) tfail("sb_if_rdata_none");
                    else begin
                        chk("sb_if_rdata", 96'(if_rdata), 96'(if_rd_q[0]));
                        if (!if_stall) void'(if_rd_q.pop_front());
                    end
                end
                if (d_req && !d_stallreq) begin
                    if (d_rd_q.size() == 0) tfail("sb_d_rdata_none");
                    else begin
                        chk("sb_d_rdata", 96'(d_rdata), 96'(d_rd_q[0]));
                        if (!d_stall) void'(d_rd_q.pop_front());
                    end
                end
            end
            cyc_prev = bus_cyc;
            if (bus_cyc) begin
                if (!in_cyc) begin
                    in_cyc = 1'b1;
                    wcnt = (slave_waits < 0) ? int'($urandom_range(0, 3)) : slave_waits;
                end
                if (wcnt == 0) begin
                    bus_ack   = 1'b1;
                    bus_rdata = use_fix ? fix_data : slave_data(bus_addr);
                    in_cyc    = 1'b0;
                    if (sb_en) begin
                        if (cur_d) pend_d = 1'b0;
                        else pend_if = 1'b0;
                    end
                end else begin
                    wcnt--;
                    bus_ack   = 1'b0;
                    bus_rdata = $urandom;
                end
            end else begin
                in_cyc    = 1'b0;
                bus_ack   = slave_force_ack;
                bus_rdata = $urandom;
            end
            snap_if = pend_if;
            snap_d  = pend_d;
        end
    end

    // Zero-wait slave for the round-robin instance
    initial begin
        rr_ack   = 1'b0;
        rr_rdata = 32'h0;
        forever begin
            @(negedge clk);
            rr_ack = rr_bus_cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_stallreq_low(input bit is_d, input string name);
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while ((is_d ? d_stallreq : if_stallreq) && guard < 60);
        if (guard >= 60) tfail(name);
    endtask

    task automatic run_port(input bit is_d, input int n);
        for (int k = 0; k < n; k++) begin
            logic [31:0] a = 32'($urandom_range(0, 16'hFFFF)) & ~32'h3;
            txn_t t;
            @(posedge clk); #1;
            if (is_d) begin
                d_we    = 1'($urandom_range(0, 1));
                d_sel   = 4'($urandom_range(1, 15));
                d_addr  = a;
                d_wdata = $urandom;
                d_req   = 1'b1;
                d_stall = 1'b1;
                t.we = d_we; t.sel = d_sel; t.addr = a; t.wdata = d_wdata;
                d_bus_q.push_back(t);
                d_rd_q.push_back(slave_data(a));
                pend_d = 1'b1;
            end else begin
                if_addr  = a;
                if_req   = 1'b1;
                if_stall = 1'b1;
                t.we = 1'b0; t.sel = 4'hF; t.addr = a; t.wdata = 32'h0;
                if_bus_q.push_back(t);
                if_rd_q.push_back(slave_data(a));
                pend_if = 1'b1;
            end
            wait_stallreq_low(is_d, is_d ? "sb_d_done_timeout" : "sb_if_done_timeout");
            repeat ($urandom_range(0, 2)) @(posedge clk);
            @(posedge clk); #1;
            if (is_d) d_stall = 1'b0; else if_stall = 1'b0;
            @(posedge clk); #1;
            if (is_d) d_req = 1'b0; else if_req = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
    endtask

    int rr_last = 0;   // model: 0 = IF last granted, 1 = data last granted

    task automatic rr_round(input bit want_if, input bit want_d, input string name);
        logic [31:0] got[$];
        logic [31:0] exp0, exp1;
        bit          prev = 1'b0;
        int          first_d;
        first_d = (want_if && want_d) ? (rr_last == 0 ? 1 : 0) : (want_d ? 1 : 0);
        exp0 = first_d ? 32'h2000 : 32'h1000;
        exp1 = first_d ? 32'h1000 : 32'h2000;
        @(posedge clk); #1;
        rr_if_req = want_if; rr_d_req = want_d; rr_if_stall = 1'b1; rr_d_stall = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (rr_bus_cyc && !prev) got.push_back(rr_bus_addr);
            prev = rr_bus_cyc;
        end
        chk({name, "_count"}, 96'(got.size()), 96'(int'(want_if) + int'(want_d)));
        if (got.size() > 0) chk({name, "_first"}, 96'(got[0]), 96'(exp0));
        if (want_if && want_d && got.size() > 1) chk({name, "_second"}, 96'(got[1]), 96'(exp1));
        rr_last = (want_if && want_d) ? (first_d ? 0 : 1) : first_d;
        @(posedge clk); #1;
        rr_if_stall = 1'b0; rr_d_stall = 1'b0;
        @(posedge clk); #1;
        rr_if_req = 1'b0; rr_d_req = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int cyc_cnt, rises;
        bit p;
        rst = 1'b1; flush = 1'b0;
        if_req = 0; if_addr = 0; if_stall = 0;
        d_req = 0; d_we = 0; d_sel = 0; d_addr = 0; d_wdata = 0; d_stall = 0;
        rr_if_req = 0; rr_d_req = 0; rr_if_stall = 0; rr_d_stall = 0;
        rr_if_addr = 32'h1000; rr_d_addr = 32'h2000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_bus_ctl", 96'({bus_cyc, bus_stb, bus_we, bus_sel}), 96'(0));
        chk("rst_bus_addr", 96'(bus_addr), 96'(0));
        chk("rst_bus_wdata", 96'(bus_wdata), 96'(0));
        chk("rst_rdata", 96'({if_rdata, d_rdata}), 96'(0));
        chk("rst_stallreq", 96'({if_stallreq, d_stallreq}), 96'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // IF-only fetch, zero-wait ack
        slave_waits = 0; use_fix = 1'b1; fix_data = 32'h3C010001;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h100; if_stall = 1'b1;
        @(negedge clk);
        chk("t1_c0", 96'({if_stallreq, bus_cyc}), 96'(2'b10));
        @(negedge clk);
        chk("t1_c1_bus", 96'({bus_stb, bus_we, bus_sel, bus_addr}), 96'({1'b1, 1'b0, 4'hF, 32'h100}));
        @(negedge clk);
        chk("t1_c2_done", 96'({if_stallreq, bus_cyc}), 96'(0));
        chk("t1_c2_rdata", 96'(if_rdata), 96'(32'h3C010001));
        @(posedge clk); #1;
        if_stall = 1'b0; use_fix = 1'b0;
        @(negedge clk);
        chk("t1_no_reissue_a", 96'(bus_cyc), 96'(0));
        @(posedge clk); #1;
        if_req = 1'b0;
        @(negedge clk);
        chk("t1_no_reissue_b", 96'(bus_cyc), 96'(0));

        // Simultaneous requests, data priority
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h400; if_stall = 1'b1;
        d_req = 1'b1; d_we = 1'b0; d_sel = 4'hF; d_addr = 32'h2000; d_wdata = 0; d_stall = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t2_data_first", 96'({bus_cyc, bus_addr}), 96'({1'b1, 32'h2000}));
        @(negedge clk);
        chk("t2_d_done", 96'({d_stallreq, if_stallreq, bus_cyc}), 96'(3'b010));
        chk("t2_d_rdata", 96'(d_rdata), 96'(slave_data(32'h2000)));
        @(negedge clk);
        chk("t2_if_second", 96'({bus_cyc, bus_addr}), 96'({1'b1, 32'h400}));
        @(negedge clk);
        chk("t2_if_rdata", 96'({if_stallreq, if_rdata}), 96'({1'b0, slave_data(32'h400)}));
        @(posedge clk); #1;
        if_stall = 1'b0; d_stall = 1'b0;
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0;

        // Store with three wait states while IF is frozen
        slave_waits = 3;
        @(posedge clk); #1;
        if_stall = 1'b1;
        d_req = 1'b1; d_we = 1'b1; d_sel = 4'b0011; d_addr = 32'h2004; d_wdata = 32'hDEADBEEF;
        d_stall = 1'b1;
        cyc_cnt = 0; rises = 0; p = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus_cyc) begin
                cyc_cnt++;
                chk("t3_bus_stable", 96'({bus_we, bus_sel, bus_addr, bus_wdata}),
                    96'({1'b1, 4'b0011, 32'h2004, 32'hDEADBEEF}));
            end
            if (bus_cyc && !p) rises++;
            p = bus_cyc;
        end
        chk("t3_stb_cycles", 96'(cyc_cnt), 96'(4));
        chk("t3_one_store", 96'(rises), 96'(1));
        chk("t3_done_held", 96'({d_stallreq, d_rdata}), 96'({1'b0, slave_data(32'h2004)}));
        @(posedge clk); #1;
        d_stall = 1'b0;
        @(posedge clk); #1;
        d_req = 1'b0; if_stall = 1'b0;

        // Flush while a fetch is on the bus
        slave_waits = 2;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h300; if_stall = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t4_inflight", 96'(bus_cyc), 96'(1));
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("t4_c3_ack", 96'(bus_ack), 96'(1));
        @(negedge clk);
        chk("t4_c4_discard", 96'({if_stallreq, bus_cyc, if_rdata}), 96'({2'b10, slave_data(32'h400)}));
        @(negedge clk);
        chk("t4_reissue", 96'({bus_cyc, bus_addr}), 96'({1'b1, 32'h300}));
        wait_stallreq_low(1'b0, "t4_done_timeout");
        chk("t4_rdata", 96'(if_rdata), 96'(slave_data(32'h300)));
        @(posedge clk); #1;
        if_stall = 1'b0;
        @(posedge clk); #1;
        if_req = 1'b0;

        // Reset while the data port owns the bus
        slave_waits = 5;
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_sel = 4'hF; d_addr = 32'h2008; d_stall = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t5_busy", 96'(bus_cyc), 96'(1));
        @(posedge clk); #1;
        rst = 1'b1; d_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; d_stall = 1'b0;
        @(negedge clk);
        chk("t5_bus_ctl", 96'({bus_cyc, bus_stb, bus_we, bus_sel}), 96'(0));
        chk("t5_bus_data", 96'({bus_addr, bus_wdata}), 96'(0));
        chk("t5_rdata", 96'({if_rdata, d_rdata}), 96'(0));

        // Spurious ack in IDLE
        slave_waits = 0; slave_force_ack = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        slave_force_ack = 1'b0;
        if_req = 1'b1; if_addr = 32'h500; if_stall = 1'b1;
        @(negedge clk);
        chk("t6_no_done", 96'({if_stallreq, bus_cyc, if_rdata}), 96'({2'b10, 32'h0}));
        @(negedge clk);
        chk("t6_issue", 96'({bus_cyc, bus_addr}), 96'({1'b1, 32'h500}));
        wait_stallreq_low(1'b0, "t6_done_timeout");
        chk("t6_rdata", 96'(if_rdata), 96'(slave_data(32'h500)));
        @(posedge clk); #1;
        if_stall = 1'b0;
        @(posedge clk); #1;
        if_req = 1'b0;

        // Round-robin instance
        rr_last = 0;
        rr_round(1'b1, 1'b1, "rr_tie1");
        rr_round(1'b0, 1'b1, "rr_d_only");
        rr_round(1'b1, 1'b1, "rr_tie2");
        rr_round(1'b1, 1'b0, "rr_if_only");
        rr_round(1'b1, 1'b1, "rr_tie3");

        // Randomized scoreboard run
        slave_waits = -1;
        pend_if = 1'b0; pend_d = 1'b0;
        repeat (3) @(posedge clk);
        sb_en = 1'b1;
        fork
            run_port(1'b0, 40);
            run_port(1'b1, 40);
        join
        repeat (6) @(posedge clk);
        sb_en = 1'b0;
        chk("sb_if_bus_left", 96'(if_bus_q.size()), 96'(0));
        chk("sb_d_bus_left", 96'(d_bus_q.size()), 96'(0));
        chk("sb_if_rd_left", 96'(if_rd_q.size()), 96'(0));
        chk("sb_d_rd_left", 96'(d_rd_q.size()), 96'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
